mask_stream_serializer: RTL and testbench

Parametrised successor to the mask serializer: accepts a full mask row on a valid/ready input port and emits it as a stream of OP_CHANNEL_WIDTH-bit beats on a valid/ready output port, using a per-row runtime-selectable stride (image resolution). Row storage is double-buffered so the next row is accepted while the current one streams out. It sits between the mask generator (row producer) and the narrow mask bus toward the pixel datapath.

---
 rtl/mask_ser_pkg.sv | 16 +
 rtl/mask_row_buffer.sv | 39 +++
 rtl/mask_stream_serializer.sv | 102 ++++++++++
 tb/tb_mask_stream_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_ser_pkg.sv
// mask_ser_pkg: resolution encoding, default beat counts and step lookup for the mask serializer
package mask_ser_pkg;
  typedef enum logic [1:0] {
    RES_S0   = 2'b00,
    RES_S1   = 2'b01,
    RES_S2   = 2'b10,
    RES_RSVD = 2'b11
  } res_e;
  localparam int DEF_STEP_SEL0 = 16;
  localparam int DEF_STEP_SEL1 = 32;
  localparam int DEF_STEP_SEL2 = 54;
  // Reserved mode streams like mode 2
  function automatic int step_of(res_e r);
    return r == RES_S0 ? DEF_STEP_SEL0 : r == RES_S1 ? DEF_STEP_SEL1 : DEF_STEP_SEL2;
  endfunction
endpackage

// File: rtl/mask_row_buffer.sv
// mask_row_buffer: one stored mask row with its resolution and an occupancy flag
module mask_row_buffer
  import mask_ser_pkg::*;
#(
  parameter int W = 1080
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         rel,
  input  logic [W-1:0] din,
  input  res_e         res_in,
  output logic [W-1:0] row,
  output res_e         res,
  output logic         occ
);
  logic [W-1:0] row_d, row_q;
  res_e         res_d, res_q;
  logic         occ_d, occ_q;
  always_comb begin
    row_d = load ? din : row_q;
    res_d = load ? res_in : res_q;
    occ_d = load | (occ_q & ~rel);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      res_q <= RES_S0;
      occ_q <= 1'b0;
    end else begin
      row_q <= row_d;
      res_q <= res_d;
      occ_q <= occ_d;
    end
  end
  assign row = row_q;
  assign res = res_q;
  assign occ = occ_q;
endmodule

// File: rtl/mask_stream_serializer.sv
// mask_stream_serializer: streams stored mask rows as strided OP_CHANNEL_WIDTH-bit beats.
// MASK_SER_DOUBLE_BUFFER_EN selects two ping-pong row buffers; otherwise a single buffer.
module mask_stream_serializer
  import mask_ser_pkg::*;
#(
  parameter int IP_CHANNEL_WIDTH = 1080,
  parameter int OP_CHANNEL_WIDTH = 20,
  parameter int STEP_SEL0        = DEF_STEP_SEL0,
  parameter int STEP_SEL1        = DEF_STEP_SEL1,
  parameter int STEP_SEL2        = DEF_STEP_SEL2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IP_CHANNEL_WIDTH-1:0] din,
  input  logic [1:0]                  image_resolution,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_CHANNEL_WIDTH-1:0] dout,
  output logic                        out_last,
  output logic [1:0]                  out_resolution
);
`ifdef MASK_SER_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int CW = $clog2(STEP_SEL2);
  localparam int IW = $clog2(IP_CHANNEL_WIDTH);

  logic [CW-1:0]               cnt_d, cnt_q;
  logic                        rd_ptr_d, rd_ptr_q, wr_ptr_d, wr_ptr_q;
  logic                        in_ready_d, in_ready_q;
  logic [IP_CHANNEL_WIDTH-1:0] row_w [2];
  res_e                        res_w [2];
  logic [1:0]                  occ, occ_n;
  logic [IP_CHANNEL_WIDTH-1:0] cur_row;
  res_e                        cur_res;
  logic [OP_CHANNEL_WIDTH-1:0] beat;
  logic                        last, hs, done, acc;
  int                          step;

  // Unused second slot in single-buffer builds reads as permanently empty
  for (genvar b = 0; b < 2; b++) begin : g_buf
    if (b < NB) begin : g_on
      mask_row_buffer #(.W(IP_CHANNEL_WIDTH)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (acc && wr_ptr_q == 1'(b)),
        .rel    (done && rd_ptr_q == 1'(b)),
        .din    (din),
        .res_in (res_e'(image_resolution)),
        .row    (row_w[b]),
        .res    (res_w[b]),
        .occ    (occ[b])
      );
    end else begin : g_off
      assign row_w[b] = '0;
      assign res_w[b] = RES_S0;
      assign occ[b]   = 1'b0;
    end
  end

  always_comb begin
    cur_row    = row_w[rd_ptr_q];
    cur_res    = res_w[rd_ptr_q];
    out_valid  = occ[rd_ptr_q];
    step       = cur_res == RES_S0 ? STEP_SEL0 : cur_res == RES_S1 ? STEP_SEL1 : STEP_SEL2;
    last       = cnt_q == CW'(step - 1);
    hs         = out_valid & out_ready;
    done       = hs & last;
    acc        = in_valid & in_ready_q;
    cnt_d      = done ? '0 : hs ? cnt_q + CW'(1) : cnt_q;
    rd_ptr_d   = (NB == 2 && done) ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d   = (NB == 2 && acc) ? ~wr_ptr_q : wr_ptr_q;
    occ_n      = 2'(occ[0]) + 2'(occ[1]) + 2'(acc) - 2'(done);
    in_ready_d = occ_n < 2'(NB);
    beat       = '0;
    for (int i = 0; i < OP_CHANNEL_WIDTH; i++)
      beat[i] = cur_row[IW'(i) * IW'(step) + IW'(cnt_q)];
    dout           = out_valid ? beat : '0;
    out_last       = out_valid & last;
    out_resolution = cur_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
endmodule

// File: tb/tb_mask_stream_serializer.sv
// tb_mask_stream_serializer: directed scenarios for the mask stream serializer
module tb_mask_stream_serializer;
  localparam int IPW = 1080;
  localparam int OPW = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IPW-1:0]  din = '0;
  logic [1:0]      image_resolution = 2'b00;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OPW-1:0]  dout;
  logic            out_last;
  logic [1:0]      out_resolution;

  int             errors = 0;
  int             checks = 0;
  logic [OPW-1:0] got [64];
  logic           got_last [64];
  logic [1:0]     got_res;
  int             nh;

  always #5 clk = ~clk;

  mask_stream_serializer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .din              (din),
    .image_resolution (image_resolution),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .dout             (dout),
    .out_last         (out_last),
    .out_resolution   (out_resolution)
  );

  function automatic logic [IPW-1:0] mk_mod(input int m, input int r);
    logic [IPW-1:0] v = '0;
    for (int j = 0; j < IPW; j++) if (j % m == r) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [IPW-1:0] mk_bits(input int a, input int b, input int c);
    logic [IPW-1:0] v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic send_row(input logic [IPW-1:0] row, input logic [1:0] res);
    int k = 0;
    din = row;
    image_resolution = res;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_row: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit stall);
    int cyc = 0;
    bit pstall = 1'b0;
    bit fin = 1'b0;
    logic [OPW-1:0] pd = '0;
    logic pl = 1'b0;
    nh = 0;
    while (!fin && cyc < 400) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (pstall) begin
        checks++;
        if (dout !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: dout=%h last=%b required %h %b", dout, out_last, pd, pl);
        end
      end
      pstall = out_valid && !out_ready;
      pd = dout;
      pl = out_last;
      if (out_valid && out_ready) begin
        if (nh < 64) begin
          got[nh] = dout;
          got_last[nh] = out_last;
        end
        got_res = out_resolution;
        nh++;
        fin = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL collect_last: no out_last within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    din = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b dout=%h last=%b required 0 0 0", out_valid, dout, out_last);
    end
    checks++;
    if (out_resolution !== 2'b00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: res=%b in_ready=%b required 00 1", out_resolution, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ignore_in: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mode01;
    send_row(mk_mod(32, 5), 2'b01);
    checks++;
    if (out_valid !== 1'b1 || dout !== 20'h0) begin
      errors++;
      $display("FAIL mode01_latency: valid=%b dout=%h required 1 00000", out_valid, dout);
    end
    collect(1'b0);
    checks++;
    if (nh !== 32 || got_res !== 2'b01) begin
      errors++;
      $display("FAIL mode01_count: beats=%0d res=%b required 32 01", nh, got_res);
    end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (got[b] !== (b == 5 ? 20'hFFFFF : 20'h0) || got_last[b] !== (b == 31)) begin
        errors++;
        $display("FAIL mode01 beat %0d: dout=%h last=%b", b, got[b], got_last[b]);
      end
    end
  endtask

  task automatic test_mode00;
    logic [IPW-1:0] v = '0;
    for (int j = 320; j < IPW; j++) v[j] = 1'b1;
    send_row(v, 2'b00);
    collect(1'b0);
    checks++;
    if (nh !== 16 || got_res !== 2'b00) begin
      errors++;
      $display("FAIL mode00_count: beats=%0d res=%b required 16 00", nh, got_res);
    end
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (got[b] !== 20'h0 || got_last[b] !== (b == 15)) begin
        errors++;
        $display("FAIL mode00 beat %0d: dout=%h last=%b", b, got[b], got_last[b]);
      end
    end
  endtask

  task automatic test_bits00;
    send_row(mk_bits(0, 17, 319), 2'b00);
    collect(1'b0);
    checks++;
    if (nh !== 16) begin
      errors++;
      $display("FAIL bits00_count: beats=%0d required 16", nh);
    end
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (got[b] !== (b == 0 ? 20'h1 : b == 1 ? 20'h2 : b == 15 ? 20'h80000 : 20'h0)) begin
        errors++;
        $display("FAIL bits00 beat %0d: dout=%h", b, got[b]);
      end
    end
  endtask

  task automatic test_mode11;
    send_row('1, 2'b11);
    collect(1'b0);
    checks++;
    if (nh !== 54 || got_res !== 2'b11) begin
      errors++;
      $display("FAIL mode11_count: beats=%0d res=%b required 54 11", nh, got_res);
    end
    for (int b = 0; b < 54; b++) begin
      checks++;
      if (got[b] !== 20'hFFFFF || got_last[b] !== (b == 53)) begin
        errors++;
        $display("FAIL mode11 beat %0d: dout=%h last=%b", b, got[b], got_last[b]);
      end
    end
  endtask

  task automatic test_backpressure;
    send_row(mk_bits(0, 55, 1079), 2'b10);
    collect(1'b1);
    checks++;
    if (nh !== 54 || got_res !== 2'b10) begin
      errors++;
      $display("FAIL bp_count: handshakes=%0d res=%b required 54 10", nh, got_res);
    end
    for (int b = 0; b < 54; b++) begin
      checks++;
      if (got[b] !== (b == 0 ? 20'h1 : b == 1 ? 20'h2 : b == 53 ? 20'h80000 : 20'h0)
          || got_last[b] !== (b == 53)) begin
        errors++;
        $display("FAIL bp beat %0d: dout=%h last=%b", b, got[b], got_last[b]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, acc0 = -1, acc1 = -1, vcnt = 0, first = -1, lastv = -1;
    int lasts = 0, hs = 0, cyc = 0, gap_req, acc_req;
    logic [IPW-1:0] rows [2];
    rows[0] = mk_mod(32, 5);
    rows[1] = mk_mod(32, 9);
    image_resolution = 2'b01;
    out_ready = 1'b1;
    while (lasts < 2 && cyc < 300) begin
      if (out_valid) begin
        vcnt++;
        if (first < 0) first = cyc;
        lastv = cyc;
        if (hs < 64) got[hs] = dout;
        hs++;
        if (out_last) lasts++;
      end
      in_valid = sent < 2;
      if (sent < 2) din = rows[sent];
      if (sent < 2 && in_ready) begin
        if (sent == 0) acc0 = cyc;
        else acc1 = cyc;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef MASK_SER_DOUBLE_BUFFER_EN
    gap_req = 0;
    acc_req = 1;
`else
    gap_req = 1;
    acc_req = 33;
`endif
    checks++;
    if (lasts !== 2 || hs !== 64) begin
      errors++;
      $display("FAIL b2b_count: lasts=%0d beats=%0d required 2 64", lasts, hs);
    end
    checks++;
    if (acc1 - acc0 !== acc_req) begin
      errors++;
      $display("FAIL b2b_accept: spacing=%0d required %0d", acc1 - acc0, acc_req);
    end
    checks++;
    if ((lastv - first + 1) - vcnt !== gap_req) begin
      errors++;
      $display("FAIL b2b_bubbles: bubbles=%0d required %0d", (lastv - first + 1) - vcnt, gap_req);
    end
    checks++;
    if (got[5] !== 20'hFFFFF || got[6] !== 20'h0 || got[41] !== 20'hFFFFF || got[37] !== 20'h0) begin
      errors++;
      $display("FAIL b2b_data: b5=%h b6=%h b41=%h b37=%h required fffff 00000 fffff 00000",
               got[5], got[6], got[41], got[37]);
    end
  endtask

  task automatic test_reset_mid;
    send_row(mk_mod(32, 5), 2'b01);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: valid=%b last=%b required 1 0", out_valid, out_last);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b in_ready=%b dout=%h required 0 1 00000", out_valid, in_ready, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_row(mk_bits(0, 17, 319), 2'b00);
    collect(1'b0);
    checks++;
    if (nh !== 16 || got[0] !== 20'h1 || got[1] !== 20'h2 || got[15] !== 20'h80000 || got_last[15] !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: beats=%0d b0=%h b1=%h b15=%h required 16 00001 00002 80000",
               nh, got[0], got[1], got[15]);
    end
  endtask

  initial begin
    test_reset;
    test_mode01;
    test_mode00;
    test_bits00;
    test_mode11;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
